display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Paced by the CEO tick from frequency_divider, which is connected to the CE input; each CE advances to the next digit.
- Inserts a blanking dead-time before each digit to prevent ghosting.
- Double-buffers display data so updates take effect only at frame boundaries, with no tearing.

---
 rtl/display_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: N-digit 7-segment scan controller with dead-time blanking and frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DEAD_CYC = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [4*N_DIGITS-1:0] DATA,
    input  logic [N_DIGITS-1:0]   DP_IN,
    input  logic                  LOAD,
    output logic [N_DIGITS-1:0]   AN,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic                  FRAME
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] stg_data_q, stg_data_d, shd_data_q, shd_data_d;
    logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic                  pend_q, pend_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d, frame_q, frame_d;
    logic                  wrap, lz;
    logic [3:0]            nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nib = shd_data_q[4*idx_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // a digit is suppressed only if it and every more-significant digit are zero
        lz = (idx_q != '0);
        for (int j = 0; j < N_DIGITS; j++)
            if (j >= int'(idx_q) && shd_data_q[4*j +: 4] != 4'h0) lz = 1'b0;
`else
        lz = 1'b0;
`endif
        wrap       = CE && state_q != BLANK && idx_q == IW'(N_DIGITS-1);
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        stg_data_d = stg_data_q;
        stg_dp_d   = stg_dp_q;
        shd_data_d = shd_data_q;
        shd_dp_d   = shd_dp_q;
        pend_d     = pend_q;
        an_d       = an_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        frame_d    = 1'b0;
        if (LOAD) begin
            stg_data_d = DATA;
            stg_dp_d   = DP_IN;
            pend_d     = 1'b1;
        end
        // shadow only changes at the frame boundary; a coincident LOAD bypasses staging
        if (wrap) begin
            frame_d = 1'b1;
            if (LOAD) begin
                shd_data_d = DATA;
                shd_dp_d   = DP_IN;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                shd_data_d = stg_data_q;
                shd_dp_d   = stg_dp_q;
                pend_d     = 1'b0;
            end
        end
        if (state_q != BLANK && CE) begin
            an_d    = '1;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
            cnt_d   = '0;
            state_d = BLANK;
            idx_d   = wrap ? '0 : idx_q + IW'(1);
        end else if (state_q == BLANK) begin
            if (cnt_q == CW'(DEAD_CYC-1)) begin
                state_d = DRIVE;
                an_d    = ~(N_DIGITS'(1) << idx_q);
                seg_d   = lz ? 7'h7F : hex7(nib);
                dp_d    = ~shd_dp_q[idx_q];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= IW'(N_DIGITS-1);
            cnt_q      <= '0;
            stg_data_q <= '0;
            stg_dp_q   <= '0;
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            pend_q     <= 1'b0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            stg_data_q <= stg_data_d;
            stg_dp_q   <= stg_dp_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench for display_scan_ctrl (N_DIGITS=4, DEAD_CYC=2) with a digit scoreboard.
// Expected digit images come from a behavioural model; define LEADING_ZERO_BLANK_EN to match that build.
module tb_display_scan_ctrl;
    localparam int DEAD = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] DATA = '0;
    logic [3:0]  DP_IN = '0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        FRAME;

    int n_checks = 0;
    int n_fail = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [11:0] sb[$];
    logic [1:0]  m_idx;
    logic [15:0] m_sh, m_stg;
    logic [3:0]  m_shdp, m_stgdp;
    logic        m_pend;
    int          m_left;
    logic [3:0]  cur_an;
    logic [6:0]  cur_seg;
    logic        cur_dp;

    display_scan_ctrl #(.N_DIGITS(4), .DEAD_CYC(DEAD)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .DATA(DATA), .DP_IN(DP_IN), .LOAD(LOAD),
        .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 2'd3; m_sh = '0; m_stg = '0; m_shdp = '0; m_stgdp = '0; m_pend = 1'b0;
        m_left = 0; cur_an = 4'hF; cur_seg = 7'h7F; cur_dp = 1'b1;
        sb.delete();
    endtask

    function automatic logic [11:0] expect_digit(input logic [1:0] i);
        logic [6:0] s;
        logic       blank;
        s = hex_tab[m_sh[4*i +: 4]];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (i != 0);
        for (int k = 0; k < 4; k++) if (k >= int'(i) && m_sh[4*k +: 4] != 0) blank = 1'b0;
`endif
        return {~(4'b0001 << i), blank ? 7'h7F : s, ~m_shdp[i]};
    endfunction

    task automatic step(input logic ce, input logic ld, input logic [15:0] d, input logic [3:0] p);
        logic wrap, started;
        CE = ce; LOAD = ld; DATA = d; DP_IN = p;
        @(posedge CLK); #1;
        CE = 1'b0; LOAD = 1'b0;
        wrap = 1'b0; started = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) {cur_an, cur_seg, cur_dp} = sb.pop_front();
            end
        end else if (ce) begin
            wrap = (m_idx == 2'd3);
            m_idx = wrap ? 2'd0 : m_idx + 2'd1;
            m_left = DEAD; started = 1'b1;
            cur_an = 4'hF; cur_seg = 7'h7F; cur_dp = 1'b1;
        end
        if (wrap && ld) begin
            m_sh = d; m_shdp = p;
        end else if (wrap && m_pend) begin
            m_sh = m_stg; m_shdp = m_stgdp; m_pend = 1'b0;
        end
        if (ld) begin
            m_stg = d; m_stgdp = p; m_pend = !wrap;
        end
        if (started) sb.push_back(expect_digit(m_idx));
        chk("AN", AN, cur_an);
        chk("SEG", SEG, cur_seg);
        chk("DP", DP, cur_dp);
        chk("FRAME", FRAME, wrap);
    endtask

    task automatic scan(input int n);
        for (int c = 0; c < n; c++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0);
            repeat (7) step(1'b0, 1'b0, 16'h0, 4'h0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_AN", AN, 4'hF);
        chk("rst_SEG", SEG, 7'h7F);
        chk("rst_DP", DP, 1'b1);
        chk("rst_FRAME", FRAME, 1'b0);
        #3 RST = 1'b0;
        // scan order over one full frame of 1234
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        scan(4);
        // double buffering: load mid-frame while digit 1 is shown
        scan(1);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 16'hABCD, 4'b0101);
        repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0);
        scan(2);
        scan(4);
        // pending load, then a LOAD coincident with the wrapping CE
        step(1'b0, 1'b1, 16'h1111, 4'hF);
        repeat (7) step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 16'h00F0, 4'h0);
        repeat (7) step(1'b0, 1'b0, 16'h0, 4'h0);
        scan(3);
        // second CE while blanking must be ignored
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (6) step(1'b0, 1'b0, 16'h0, 4'h0);
        scan(3);
        // leading zeros
        step(1'b0, 1'b1, 16'h0050, 4'h0);
        scan(4);
        // asynchronous reset while a digit is driven
        step(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_AN", AN, 4'hF);
        chk("mid_rst_SEG", SEG, 7'h7F);
        chk("mid_rst_DP", DP, 1'b1);
        chk("mid_rst_FRAME", FRAME, 1'b0);
        model_reset();
        #3 RST = 1'b0;
        scan(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
